lsu_mem64: RTL and testbench
============================

// Module: lsu_mem64
// PURPOSE
//  Load/store unit between the multicycle RISC-V datapath (ALU-out address, reg-B store data) and the
//  64-bit-wide data memory. Performs byte/half/word/dword loads with sign/zero extension, and sub-dword
//  stores via read-modify-write, because the data memory only writes whole doublewords. Flags misaligned
//  accesses without touching memory so the control unit can trap via EPC. Sits directly downstream of
//  the datapath: it consumes the datapath's address/data and feeds the MDR-side load result back.
// PARAMETERS
//  MEM_RD_LAT  1   cycles from mem_addr valid to mem_rdata valid (1..3)
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high
//  req_valid        in   1   request strobe; accepted when req_valid & req_ready
//  req_ready        out  1   high only in IDLE
//  req_store        in   1   1=store, 0=load
//  req_size         in   2   0=byte 1=half 2=word 3=dword
//  req_unsigned     in   1   load zero-extends when 1 (ignored for stores and dword)
//  req_addr         in   64  byte address
//  req_wdata        in   64  store data, right-justified
//  resp_valid       out  1   one-cycle completion pulse
//  resp_misaligned  out  1   valid with resp_valid; 1 = access aborted
//  resp_rdata       out  64  extended load result; held until the next load completes
//  mem_addr         out  64  {addr[63:3],3'b000}; drives both memory read and write address
//  mem_wdata        out  64  full doubleword written
//  mem_wr           out  1   memory write enable, exactly one cycle per store
//  mem_rdata        in   64  memory read data
// BEHAVIOUR
//  Reset (async): state=IDLE, req_ready=1, resp_valid=0, resp_misaligned=0, resp_rdata=0, mem_wr=0,
//   mem_addr=0, mem_wdata=0. Reset during any state aborts: no write issued, no response.
//  Request fields are latched on acceptance. req_valid outside IDLE is ignored (no queueing).
//  Lane: off=addr[2:0]; little-endian; a byte lane sits at bits [off*8 +: 8], other sizes likewise.
//  Misaligned: addr mod (1<<size) != 0 -> IDLE->RESP, no memory access, resp_misaligned=1, resp_rdata held.
//  FSM states: IDLE, RD_WAIT, WRITE, RESP.
//   IDLE   : on accept -> misaligned ? RESP : (load | sub-dword store) ? RD_WAIT : WRITE.
//   RD_WAIT: mem_addr held; wait counter counts MEM_RD_LAT cycles, then sample mem_rdata.
//            load -> extract+extend into resp_rdata, -> RESP. store -> merge req_wdata into lanes, -> WRITE.
//   WRITE  : mem_wr=1 for one cycle with merged (or full dword) mem_wdata -> RESP.
//   RESP   : resp_valid=1 one cycle -> IDLE (req_ready=1 the following cycle).
//  Latency (accept edge = cycle 0, resp_valid high during cycle): load = 1+MEM_RD_LAT;
//   dword store = 2; sub-dword store = 2+MEM_RD_LAT; misaligned = 1.
//  Merge: bytes outside the target lanes keep the read value bit-exactly.
//  Extension: signed -> replicate MSB of selected field to bit 63; unsigned -> zero fill; dword unchanged.
//  Memory assumed single-port with write taking effect at the WRITE edge; no other master between
//   RD_WAIT and WRITE (control unit guarantees exclusivity).
// STRUCTURE
//  Package lsu_pkg: typedef enum logic[1:0] {SZ_B,SZ_H,SZ_W,SZ_D} lsu_size_t;
//   typedef enum logic[1:0] {S_IDLE,S_RD_WAIT,S_WRITE,S_RESP} lsu_state_t; function size_mask(size,off).
//  Sub-module lsu_lane_extract (combinational): (rdata, off, size, unsigned) -> 64-bit extended result.
//  Top holds FSM, wait counter, latched request, merge logic, output registers.
// TESTING
//  1 mem[0x10]=0x8877665544332211; load byte, signed, addr 0x17 -> resp_rdata=0xFFFFFFFFFFFFFF88, cycle 2.
//  2 same word; load half unsigned at 0x16 -> 0x0000000000008877; word signed at 0x14 -> 0xFFFFFFFF88776655.
//  3 store byte 0xAB at 0x12 -> single mem_wr, mem[0x10]=0x8877665544AB2211, resp at cycle 3.
//  4 store dword 0x0123456789ABCDEF at 0x18 -> no read phase, mem_wr in cycle 1, resp cycle 2.
//  5 load word at 0x0A -> resp_misaligned=1 at cycle 1, mem_wr never high, resp_rdata unchanged.
//  6 sub-word store, assert reset in RD_WAIT -> mem_wr stays 0, memory unchanged, outputs at reset values;
//    req_valid held high while busy -> second request not accepted until req_ready returns.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the 64-bit load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_t;
   typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WRITE, S_RESP} lsu_state_t;

   // Bit mask covering the bytes touched by an access of 'size' at byte offset 'off'
   function automatic logic [63:0] size_mask(lsu_size_t size, logic [2:0] off);
      logic [63:0] base;
      case (size)
         SZ_B:    base = 64'h0000_0000_0000_00FF;
         SZ_H:    base = 64'h0000_0000_0000_FFFF;
         SZ_W:    base = 64'h0000_0000_FFFF_FFFF;
         default: base = '1;
      endcase
      return base << {off, 3'b000};
   endfunction

   // Natural alignment check: offset must be a multiple of the access size
   function automatic logic is_misaligned(lsu_size_t size, logic [2:0] off);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         SZ_W:    return off[1:0] != 2'b00;
         default: return off != 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem64_if.sv
// Request/response and data-memory bus of the load/store unit.
interface lsu_mem64_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_misaligned;
   logic [63:0] resp_rdata;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_wr;
   logic [63:0] mem_rdata;

   // Datapath/memory side: issues requests and returns memory read data
   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_misaligned, resp_rdata, mem_addr, mem_wdata, mem_wr
   );

   // LSU side
   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_misaligned, resp_rdata, mem_addr, mem_wdata, mem_wr
   );
endinterface

// File: rtl/lsu_lane_extract.sv
// Selects the addressed lane of a memory doubleword and sign/zero extends it.
module lsu_lane_extract
   import lsu_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  off,
   input  lsu_size_t   size,
   input  logic        is_unsigned,
   output logic [63:0] result
);

   logic [63:0] shifted;

   assign shifted = rdata >> {off, 3'b000};

   // Right-justify the field then replicate its MSB (or zero fill) up to bit 63
   always_comb begin
      result = shifted;
      case (size)
         SZ_B: result = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         SZ_H: result = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         SZ_W: result = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_mem64.sv
// Load/store unit: sub-dword loads with extension, sub-dword stores via
// read-modify-write on a doubleword-only memory, misaligned access abort.
module lsu_mem64
   import lsu_pkg::*;
#(
   parameter int MEM_RD_LAT = 1
)(
   input  logic        clock,
   input  logic        reset,
   lsu_mem64_if.slave  bus
);

   lsu_state_t  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        store_q, store_d;
   lsu_size_t   size_q, size_d;
   logic        uns_q, uns_d;
   logic [2:0]  off_q, off_d;
   logic [63:0] wdata_q, wdata_d;
   logic        mis_q, mis_d;
   logic [63:0] mem_addr_q, mem_addr_d;
   logic [63:0] mem_wdata_q, mem_wdata_d;
   logic [63:0] rdata_q, rdata_d;

   lsu_size_t   req_size;
   logic        req_mis;
   logic [63:0] lane_mask;
   logic [63:0] merged;
   logic [63:0] ext_data;

   assign req_size = lsu_size_t'(bus.req_size);
   assign req_mis  = is_misaligned(req_size, bus.req_addr[2:0]);

   // Store merge: target lanes from the shifted store data, the rest keep the read value
   assign lane_mask = size_mask(size_q, off_q);
   assign merged    = (bus.mem_rdata & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);

   lsu_lane_extract u_extract (
      .rdata       (bus.mem_rdata),
      .off         (off_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .result      (ext_data)
   );

   // Next-state, request latch and datapath register updates
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      store_d     = store_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      mis_d       = mis_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               store_d = bus.req_store;
               size_d  = req_size;
               uns_d   = bus.req_unsigned;
               off_d   = bus.req_addr[2:0];
               wdata_d = bus.req_wdata;
               mis_d   = req_mis;
               cnt_d   = 2'd0;
               if (req_mis) begin
                  // Abort without touching memory; address/data registers stay as they were
                  state_d = S_RESP;
               end else begin
                  mem_addr_d = {bus.req_addr[63:3], 3'b000};
                  if (!bus.req_store || req_size != SZ_D) begin
                     state_d = S_RD_WAIT;
                  end else begin
                     mem_wdata_d = bus.req_wdata;
                     state_d     = S_WRITE;
                  end
               end
            end
         end
         S_RD_WAIT: begin
            if (cnt_q == 2'(MEM_RD_LAT - 1)) begin
               if (store_q) begin
                  mem_wdata_d = merged;
                  state_d     = S_WRITE;
               end else begin
                  rdata_d = ext_data;
                  state_d = S_RESP;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any access in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         store_q     <= 1'b0;
         size_q      <= SZ_B;
         uns_q       <= 1'b0;
         off_q       <= 3'd0;
         wdata_q     <= '0;
         mis_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         store_q     <= store_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         mis_q       <= mis_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.req_ready       = (state_q == S_IDLE);
   assign bus.resp_valid      = (state_q == S_RESP);
   assign bus.resp_misaligned = (state_q == S_RESP) && mis_q;
   assign bus.resp_rdata      = rdata_q;
   assign bus.mem_addr        = mem_addr_q;
   assign bus.mem_wdata       = mem_wdata_q;
   assign bus.mem_wr          = (state_q == S_WRITE);

endmodule

// File: tb/tb_lsu_mem64.sv
// Scoreboard bench for lsu_mem64 with a small doubleword memory model.
module tb_lsu_mem64;
   localparam int LAT = 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic mem_init = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   lsu_mem64_if bus ();

   lsu_mem64 #(.MEM_RD_LAT(LAT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [63:0] init_val(int i);
      if (i == 2) return 64'h8877_6655_4433_2211;
      return 64'hF0E1_D2C3_B4A5_9687 ^ (64'(i) * 64'h1357_9BDF_2468_ACE1);
   endfunction

   // Memory: combinational read (single-cycle latency seen by the LSU), write at the edge
   logic [63:0] mem [16];
   assign bus.mem_rdata = mem[bus.mem_addr[6:3]];
   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      end else if (bus.mem_wr) begin
         mem[bus.mem_addr[6:3]] <= bus.mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
      end
   endtask

   // Scoreboard item and reference model state
   typedef struct {
      logic        store;
      logic        mis;
      logic [63:0] rdata;
      int          lat;
      int          wr_lat;
   } exp_t;
   exp_t        sb[$];
   logic [63:0] model_mem [16];
   logic [63:0] last_rd = '0;

   function automatic logic [63:0] ext_model(logic [63:0] d, int off, int size, logic uns);
      logic [63:0] r;
      int nb;
      nb = 1 << size;
      r  = '0;
      for (int i = 0; i < nb; i++) r[i*8 +: 8] = d[(off+i)*8 +: 8];
      if (!uns)
         for (int b = nb*8; b < 64; b++) r[b] = r[nb*8-1];
      return r;
   endfunction

   task automatic push_exp(input logic st, input int size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wd);
      exp_t e;
      int   off, idx, nb;
      off = int'(addr[2:0]);
      idx = int'(addr[6:3]);
      nb  = 1 << size;
      e.store = st;
      e.mis   = (off % nb) != 0;
      e.wr_lat = 0;
      if (e.mis) begin
         e.lat = 1;
      end else if (!st) begin
         last_rd = ext_model(model_mem[idx], off, size, uns);
         e.lat   = 1 + LAT;
      end else begin
         for (int i = 0; i < nb; i++) model_mem[idx][(off+i)*8 +: 8] = wd[i*8 +: 8];
         e.lat    = (size == 3) ? 2 : 2 + LAT;
         e.wr_lat = e.lat - 1;
      end
      e.rdata = last_rd;
      sb.push_back(e);
   endtask

   // Monitor: acceptance, write pulses and responses, sampled on the falling edge
   int n_acc = 0, acc_cyc = 0, nwr = 0, wr_lat = 0;
   always @(negedge clock) begin
      if (!reset && !mem_init) begin
         if (bus.req_valid && bus.req_ready) begin
            acc_cyc = cyc + 1;
            nwr     = 0;
            n_acc++;
         end
         if (bus.mem_wr) begin
            nwr++;
            wr_lat = cyc - acc_cyc + 1;
         end
         if (bus.resp_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", 64'(1), 64'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("resp_mis",   64'(bus.resp_misaligned), 64'(e.mis));
               chk("resp_rdata", bus.resp_rdata, e.rdata);
               chk("resp_lat",   64'(cyc - acc_cyc + 1), 64'(e.lat));
               if (e.store && !e.mis) begin
                  chk("wr_count", 64'(nwr), 64'(1));
                  chk("wr_cycle", 64'(wr_lat), 64'(e.wr_lat));
               end else begin
                  chk("wr_count", 64'(nwr), 64'(0));
               end
            end
         end
      end
   end

   task automatic wait_idle_resp();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(posedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         chk("resp_timeout", 64'(sb.size()), 64'(0));
         sb.delete();
      end
      @(posedge clock); #2;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.req_ready && n < 30) begin
         @(posedge clock); #2;
         n++;
      end
      if (!bus.req_ready) chk("ready_timeout", 64'(0), 64'(1));
   endtask

   task automatic drive(input logic st, input int size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd);
      bus.req_store    = st;
      bus.req_size     = 2'(size);
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      bus.req_valid    = 1'b1;
   endtask

   task automatic issue(input logic st, input int size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd);
      wait_ready();
      push_exp(st, size, uns, addr, wd);
      drive(st, size, uns, addr, wd);
      @(posedge clock); #2;
      bus.req_valid = 1'b0;
      wait_idle_resp();
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_ready"},     64'(bus.req_ready), 64'(1));
      chk({pfx, "_resp_vld"},  64'(bus.resp_valid), 64'(0));
      chk({pfx, "_resp_mis"},  64'(bus.resp_misaligned), 64'(0));
      chk({pfx, "_resp_rd"},   bus.resp_rdata, 64'(0));
      chk({pfx, "_mem_wr"},    64'(bus.mem_wr), 64'(0));
      chk({pfx, "_mem_addr"},  bus.mem_addr, 64'(0));
      chk({pfx, "_mem_wdata"}, bus.mem_wdata, 64'(0));
   endtask

   initial begin
      int n0;
      bus.req_valid = 1'b0;
      drive(1'b0, 0, 1'b0, '0, '0);
      bus.req_valid = 1'b0;
      for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
      #1;
      check_reset_vals("rst");
      @(posedge clock); #2;
      reset = 1'b0;
      mem_init = 1'b0;
      @(posedge clock); #2;

      // Loads from the reference doubleword
      issue(1'b0, 0, 1'b0, 64'h17, '0);
      chk("t1_byte_s", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FF88);
      issue(1'b0, 1, 1'b1, 64'h16, '0);
      chk("t2_half_u", bus.resp_rdata, 64'h0000_0000_0000_8877);
      issue(1'b0, 2, 1'b0, 64'h14, '0);
      chk("t2_word_s", bus.resp_rdata, 64'hFFFF_FFFF_8877_6655);

      // Sub-dword store via read-modify-write, then full dword store
      issue(1'b1, 0, 1'b0, 64'h12, 64'hAB);
      chk("t3_mem", mem[2], 64'h8877_6655_44AB_2211);
      issue(1'b1, 3, 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF);
      chk("t4_mem", mem[3], 64'h0123_4567_89AB_CDEF);

      // Misaligned word load: aborted, rdata held from the previous load
      issue(1'b0, 2, 1'b0, 64'h0A, '0);
      chk("t5_rd_held", bus.resp_rdata, 64'hFFFF_FFFF_8877_6655);

      // Reset while a sub-word store waits for its read data
      wait_ready();
      drive(1'b1, 1, 1'b0, 64'h22, 64'hBEEF);
      @(posedge clock); #2;
      bus.req_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_reset_vals("t6");
      @(posedge clock); #2;
      reset = 1'b0;
      last_rd = '0;
      @(posedge clock); #2;
      chk("t6_mem", mem[4], model_mem[4]);
      chk("t6_ready", 64'(bus.req_ready), 64'(1));

      // req_valid held across a busy period: second accept only after return to idle
      n0 = n_acc;
      push_exp(1'b0, 3, 1'b0, 64'h10, '0);
      push_exp(1'b0, 3, 1'b0, 64'h10, '0);
      drive(1'b0, 3, 1'b0, 64'h10, '0);
      repeat (2 + LAT + 1) @(posedge clock);
      #2;
      bus.req_valid = 1'b0;
      wait_idle_resp();
      chk("t6_accepts", 64'(n_acc - n0), 64'(2));

      // Mixed random traffic, mostly aligned
      for (int k = 0; k < 24; k++) begin
         logic [63:0] a, wd;
         int sz;
         sz = int'($urandom_range(0, 3));
         a  = 64'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
         wd = {$urandom, $urandom};
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd);
      end
      for (int i = 0; i < 16; i++) chk("final_mem", mem[i], model_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
